// File: rtl/vga_timing_pkg.sv
// Shared timing presets and helpers for the VGA raster generator.
package vga_timing_pkg;

    // SVGA 800x600 @ 72 Hz, 50 MHz pixel clock, positive syncs
    localparam int   SVGA_H_VISIBLE = 800;
    localparam int   SVGA_H_FRONT   = 56;
    localparam int   SVGA_H_SYNC    = 120;
    localparam int   SVGA_H_BACK    = 64;
    localparam int   SVGA_V_VISIBLE = 600;
    localparam int   SVGA_V_FRONT   = 37;
    localparam int   SVGA_V_SYNC    = 6;
    localparam int   SVGA_V_BACK    = 23;
    localparam logic SVGA_HS_POL    = 1'b1;
    localparam logic SVGA_VS_POL    = 1'b1;

    // VGA 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
    localparam int   VGA640_H_VISIBLE = 640;
    localparam int   VGA640_H_FRONT   = 16;
    localparam int   VGA640_H_SYNC    = 96;
    localparam int   VGA640_H_BACK    = 48;
    localparam int   VGA640_V_VISIBLE = 480;
    localparam int   VGA640_V_FRONT   = 10;
    localparam int   VGA640_V_SYNC    = 2;
    localparam int   VGA640_V_BACK    = 33;
    localparam logic VGA640_HS_POL    = 1'b0;
    localparam logic VGA640_VS_POL    = 1'b0;

    // Flags carried from the stage-0 decode down to the output register
    typedef struct packed {
        logic active;
        logic hs_act;
        logic vs_act;
    } sync_flags_t;

    // Period of one axis (line or frame) from its four segments
    function automatic int timing_total(input int vis, input int fp, input int sp, input int bp);
        return vis + fp + sp + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// DEPTH-stage shift register with an asynchronously loaded idle value.
// DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
    parameter int W     = 3,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_rst_val,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = ^{clk, rst_n, i_rst_val};
            assign o_q      = i_d;
        end else begin : g_pipe
            logic [W-1:0] r_stage [DEPTH];

            // Shift one stage per clock; reset loads the idle value everywhere
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= i_rst_val;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, stage-0 pixel request decode,
// sync/blank delay matched to the pixel source latency, registered pins.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE_AREA = SVGA_H_VISIBLE,
    parameter int   H_FRONT_PORCH  = SVGA_H_FRONT,
    parameter int   H_SYNC_PULSE   = SVGA_H_SYNC,
    parameter int   H_BACK_PORCH   = SVGA_H_BACK,
    parameter int   V_VISIBLE_AREA = SVGA_V_VISIBLE,
    parameter int   V_FRONT_PORCH  = SVGA_V_FRONT,
    parameter int   V_SYNC_PULSE   = SVGA_V_SYNC,
    parameter int   V_BACK_PORCH   = SVGA_V_BACK,
    parameter logic HSYNC_POLARITY = SVGA_HS_POL,
    parameter logic VSYNC_POLARITY = SVGA_VS_POL,
    parameter int   COLOR_W        = 4,
    parameter int   PIPE_LAT       = 1,
    localparam int  H_TOTAL = timing_total(H_VISIBLE_AREA, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH),
    localparam int  V_TOTAL = timing_total(V_VISIBLE_AREA, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH),
    localparam int  HW      = $clog2(H_TOTAL),
    localparam int  VW      = $clog2(V_TOTAL)
) (
    input  logic               VGA_CLK,
    input  logic               RESET_N,
    input  logic               EN,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic               pixel_req,
    output logic [HW-1:0]      pixel_x,
    output logic [VW-1:0]      pixel_y,
    output logic               frame_start,
    output logic               line_start,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS
);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END   = HW'(H_VISIBLE_AREA);
    localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END   = VW'(V_VISIBLE_AREA);
    localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    logic               w_run;
    logic [HW-1:0]      r_h;
    logic [VW-1:0]      r_v;
    logic               w_h_vis;
    logic               w_v_vis;
    sync_flags_t        w_flags_s0;
    sync_flags_t        w_flags_d;
    logic [COLOR_W-1:0] r_vga_r;
    logic [COLOR_W-1:0] r_vga_g;
    logic [COLOR_W-1:0] r_vga_b;
    logic               r_vga_hs;
    logic               r_vga_vs;

    // Assert asynchronously, release two clocks after RESET_N rises
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];
    assign w_run   = EN & w_rst_n;

    // Raster counters; EN low parks both at the origin so scanning resumes at frame start
    always_ff @(posedge VGA_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (!EN) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    assign w_h_vis           = (r_h < H_VIS_END);
    assign w_v_vis           = (r_v < V_VIS_END);
    assign w_flags_s0.active = w_run & w_h_vis & w_v_vis;
    assign w_flags_s0.hs_act = w_run & (r_h >= H_SYNC_BEG) & (r_h < H_SYNC_END);
    assign w_flags_s0.vs_act = w_run & (r_v >= V_SYNC_BEG) & (r_v < V_SYNC_END);

    assign pixel_req   = w_flags_s0.active;
    assign pixel_x     = w_flags_s0.active ? r_h : '0;
    assign pixel_y     = w_flags_s0.active ? r_v : '0;
    assign frame_start = w_run & (r_h == '0) & (r_v == '0);
    assign line_start  = w_run & (r_h == '0) & w_v_vis;

    vga_delay_line #(
        .W     ($bits(sync_flags_t)),
        .DEPTH (PIPE_LAT)
    ) u_flag_delay (
        .clk       (VGA_CLK),
        .rst_n     (w_rst_n),
        .i_rst_val ('0),
        .i_d       (w_flags_s0),
        .o_q       (w_flags_d)
    );

    // Pin register: delayed flags meet the returned pixel on the same edge
    always_ff @(posedge VGA_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vga_r  <= '0;
            r_vga_g  <= '0;
            r_vga_b  <= '0;
            r_vga_hs <= ~HSYNC_POLARITY;
            r_vga_vs <= ~VSYNC_POLARITY;
        end else begin
            r_vga_r  <= w_flags_d.active ? pix_r : '0;
            r_vga_g  <= w_flags_d.active ? pix_g : '0;
            r_vga_b  <= w_flags_d.active ? pix_b : '0;
            r_vga_hs <= w_flags_d.hs_act ? HSYNC_POLARITY : ~HSYNC_POLARITY;
            r_vga_vs <= w_flags_d.vs_act ? VSYNC_POLARITY : ~VSYNC_POLARITY;
        end
    end

    assign VGA_R  = r_vga_r;
    assign VGA_G  = r_vga_g;
    assign VGA_B  = r_vga_b;
    assign VGA_HS = r_vga_hs;
    assign VGA_VS = r_vga_vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (tiny/lat2/pos, tiny/lat0/neg,
// SVGA defaults/lat1) share EN and RESET_N and are checked every clock
// against an arithmetic raster model (position n -> h = n mod H_TOTAL, ...).
module tb_vga_timing_gen;

    localparam int ND   = 3;
    localparam int MAXC = 6000;

    localparam int HV   [ND] = '{8, 8, 800};
    localparam int HF   [ND] = '{2, 2, 56};
    localparam int HSP  [ND] = '{3, 3, 120};
    localparam int HB   [ND] = '{1, 1, 64};
    localparam int VV   [ND] = '{4, 4, 600};
    localparam int VF   [ND] = '{1, 1, 37};
    localparam int VSP  [ND] = '{2, 2, 6};
    localparam int VB   [ND] = '{1, 1, 23};
    localparam int LAT  [ND] = '{2, 0, 1};
    localparam int HPOL [ND] = '{1, 0, 1};
    localparam int VPOL [ND] = '{1, 0, 1};

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic [3:0] pr [ND];
    logic [3:0] pg [ND];
    logic [3:0] pb [ND];

    logic       req0, fs0, ls0, hs0, vs0;
    logic [3:0] px0;
    logic [2:0] py0;
    logic [3:0] r0, g0, b0;
    logic       req1, fs1, ls1, hs1, vs1;
    logic [3:0] px1;
    logic [2:0] py1;
    logic [3:0] r1, g1, b1;
    logic       req2, fs2, ls2, hs2, vs2;
    logic [10:0] px2;
    logic [9:0]  py2;
    logic [3:0]  r2, g2, b2;

    int errors, checks;
    int cyc, n, rel_cnt, last_rst, t0;
    int hist_n [MAXC];
    int seed_g, seed_b;
    int cnt_req, cnt_vs, cnt_hs;
    bit expect_fs, expect_rst;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE_AREA(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(1),
        .V_VISIBLE_AREA(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .HSYNC_POLARITY(1'b1), .VSYNC_POLARITY(1'b1), .COLOR_W(4), .PIPE_LAT(2)
    ) u_dut0 (
        .VGA_CLK(clk), .RESET_N(rst_n), .EN(en),
        .pix_r(pr[0]), .pix_g(pg[0]), .pix_b(pb[0]),
        .pixel_req(req0), .pixel_x(px0), .pixel_y(py0),
        .frame_start(fs0), .line_start(ls0),
        .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0)
    );

    vga_timing_gen #(
        .H_VISIBLE_AREA(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(1),
        .V_VISIBLE_AREA(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .HSYNC_POLARITY(1'b0), .VSYNC_POLARITY(1'b0), .COLOR_W(4), .PIPE_LAT(0)
    ) u_dut1 (
        .VGA_CLK(clk), .RESET_N(rst_n), .EN(en),
        .pix_r(pr[1]), .pix_g(pg[1]), .pix_b(pb[1]),
        .pixel_req(req1), .pixel_x(px1), .pixel_y(py1),
        .frame_start(fs1), .line_start(ls1),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1)
    );

    vga_timing_gen u_dut2 (
        .VGA_CLK(clk), .RESET_N(rst_n), .EN(en),
        .pix_r(pr[2]), .pix_g(pg[2]), .pix_b(pb[2]),
        .pixel_req(req2), .pixel_x(px2), .pixel_y(py2),
        .frame_start(fs2), .line_start(ls2),
        .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .VGA_HS(hs2), .VGA_VS(vs2)
    );

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", name, d, cyc, act, exp);
        end
    endtask

    // Raster position -> counters and region flags, straight from the timing rules
    function automatic void decode(input int d, input int nn, output bit act, output bit hsa,
                                   output bit vsa, output int h, output int v);
        int ht, vt;
        ht = HV[d] + HF[d] + HSP[d] + HB[d];
        vt = VV[d] + VF[d] + VSP[d] + VB[d];
        if (nn < 0) begin
            act = 0; hsa = 0; vsa = 0; h = 0; v = 0;
        end else begin
            h   = nn % ht;
            v   = (nn / ht) % vt;
            act = (h < HV[d]) && (v < VV[d]);
            hsa = (h >= HV[d] + HF[d]) && (h < HV[d] + HF[d] + HSP[d]);
            vsa = (v >= VV[d] + VF[d]) && (v < VV[d] + VF[d] + VSP[d]);
        end
    endfunction

    // Framebuffer content the bench serves for coordinate (x, y)
    function automatic int fcol(input int ch, input int x, input int y);
        case (ch)
            0:       return x & 15;
            1:       return (x + 2 * y + seed_g) & 15;
            default: return ((3 * x) ^ y ^ seed_b) & 15;
        endcase
    endfunction

    task automatic grab(input int d, output int a_req, output int a_x, output int a_y,
                        output int a_fs, output int a_ls, output int a_r, output int a_g,
                        output int a_b, output int a_hs, output int a_vs);
        case (d)
            0: begin
                a_req = int'(req0); a_x = int'(px0); a_y = int'(py0); a_fs = int'(fs0); a_ls = int'(ls0);
                a_r = int'(r0); a_g = int'(g0); a_b = int'(b0); a_hs = int'(hs0); a_vs = int'(vs0);
            end
            1: begin
                a_req = int'(req1); a_x = int'(px1); a_y = int'(py1); a_fs = int'(fs1); a_ls = int'(ls1);
                a_r = int'(r1); a_g = int'(g1); a_b = int'(b1); a_hs = int'(hs1); a_vs = int'(vs1);
            end
            default: begin
                a_req = int'(req2); a_x = int'(px2); a_y = int'(py2); a_fs = int'(fs2); a_ls = int'(ls2);
                a_r = int'(r2); a_g = int'(g2); a_b = int'(b2); a_hs = int'(hs2); a_vs = int'(vs2);
            end
        endcase
    endtask

    // One clock: called just after a negedge with en/rst_n already set for this cycle
    task automatic step();
        bit run, act, hsa, vsa;
        int h, v, s, nn, k;
        int a_req, a_x, a_y, a_fs, a_ls, a_r, a_g, a_b, a_hs, a_vs;
        if (!rst_n) begin
            last_rst = cyc;
            rel_cnt  = 0;
        end
        run = en && rst_n && (rel_cnt >= 2);
        hist_n[cyc] = run ? n : -1;

        for (int d = 0; d < ND; d++) begin
            s  = cyc - LAT[d];
            nn = (s >= 0) ? hist_n[s] : -1;
            decode(d, nn, act, hsa, vsa, h, v);
            if (act) begin
                pr[d] = 4'(fcol(0, h, v));
                pg[d] = 4'(fcol(1, h, v));
                pb[d] = 4'(fcol(2, h, v));
            end else begin
                pr[d] = 4'($urandom_range(0, 15));
                pg[d] = 4'($urandom_range(0, 15));
                pb[d] = 4'($urandom_range(0, 15));
            end
        end

        #1;
        for (int d = 0; d < ND; d++) begin
            grab(d, a_req, a_x, a_y, a_fs, a_ls, a_r, a_g, a_b, a_hs, a_vs);
            decode(d, hist_n[cyc], act, hsa, vsa, h, v);
            chk("pixel_req", d, a_req, int'(act));
            chk("pixel_x", d, a_x, act ? h : 0);
            chk("pixel_y", d, a_y, act ? v : 0);
            chk("frame_start", d, a_fs, int'(run && h == 0 && v == 0));
            chk("line_start", d, a_ls, int'(run && h == 0 && v < VV[d]));

            s  = cyc - LAT[d] - 1;
            nn = (s < 0 || s <= last_rst) ? -1 : hist_n[s];
            decode(d, nn, act, hsa, vsa, h, v);
            chk("vga_r", d, a_r, act ? fcol(0, h, v) : 0);
            chk("vga_g", d, a_g, act ? fcol(1, h, v) : 0);
            chk("vga_b", d, a_b, act ? fcol(2, h, v) : 0);
            chk("vga_hs", d, a_hs, hsa ? HPOL[d] : 1 - HPOL[d]);
            chk("vga_vs", d, a_vs, vsa ? VPOL[d] : 1 - VPOL[d]);
        end

        if (expect_rst) begin
            chk("lit_rst_hs", 0, int'(hs0), 0);
            chk("lit_rst_vs", 0, int'(vs0), 0);
            chk("lit_rst_hs", 1, int'(hs1), 1);
            chk("lit_rst_vs", 1, int'(vs1), 1);
            chk("lit_rst_r", 0, int'(r0), 0);
            chk("lit_rst_req", 2, int'(req2), 0);
            expect_rst = 0;
        end
        if (expect_fs) begin
            chk("lit_restart_fs", 0, int'(fs0), 1);
            chk("lit_restart_px", 0, int'(px0), 0);
            chk("lit_restart_py", 0, int'(py0), 0);
            expect_fs = 0;
        end

        if (t0 >= 0) begin
            k = cyc - t0;
            if (k == 0)  chk("lit_first_fs", 2, int'(fs2), 1);
            if (k >= 0 && k < 112) cnt_req += int'(req0);
            if (k == 112) chk("lit_req_per_frame", 0, cnt_req, 32);
            if (k >= 3 && k < 115 && vs0) cnt_vs++;
            if (k == 115) chk("lit_vs_width", 0, cnt_vs, 28);
            if (k >= 3 && k <= 10) chk("lit_r_ramp", 0, int'(r0), k - 3);
            if (k == 11) chk("lit_r_blank", 0, int'(r0), 0);
            if (k == 12) chk("lit_hs_before_edge", 0, int'(hs0), 0);
            if (k == 13) chk("lit_hs_edge", 0, int'(hs0), 1);
            if (k == 2)  chk("lit_r_lat0", 1, int'(r1), 1);
            if (k == 10) chk("lit_hs_lat0_idle", 1, int'(hs1), 1);
            if (k == 11) chk("lit_hs_lat0_edge", 1, int'(hs1), 0);
            if (k == 799) chk("lit_last_x", 2, int'(px2), 799);
            if (k == 800) chk("lit_blank_req", 2, int'(req2), 0);
            if (k >= 2 && k < 1042 && hs2) cnt_hs++;
            if (k == 1040) chk("lit_line2_start", 2, int'(ls2), 1);
            if (k == 1042) chk("lit_hs_width", 2, cnt_hs, 120);
        end

        @(posedge clk);
        if (rst_n && rel_cnt < 2) rel_cnt++;
        n = run ? n + 1 : 0;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; n = 0; rel_cnt = 0; last_rst = 0; t0 = -1;
        cnt_req = 0; cnt_vs = 0; cnt_hs = 0; expect_fs = 0; expect_rst = 0;
        seed_g = int'($urandom_range(0, 15));
        seed_b = int'($urandom_range(0, 15));
        for (int d = 0; d < ND; d++) begin
            pr[d] = '0; pg[d] = '0; pb[d] = '0;
        end
        rst_n = 1'b1;
        en    = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);

        // Reset state, then uninterrupted scan from release
        expect_rst = 1;
        repeat (3) step();
        rst_n = 1'b1;
        t0 = cyc + 2;
        repeat (1100) step();
        t0 = -1;

        // EN dropped mid-frame for 50 clocks, restart lands on frame_start
        en = 1'b0;
        repeat (50) step();
        en = 1'b1;
        expect_fs = 1;
        step();

        // Reset pulse mid-frame, then release through the synchroniser
        repeat (37) step();
        rst_n = 1'b0;
        expect_rst = 1;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        expect_fs = 1;
        step();

        // Randomised EN toggling and occasional one-clock reset pulses
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
